rx_fc_credit_buffer: RTL and testbench
======================================

RX_FC_CREDIT_BUFFER -- requirements
Module: rx_fc_credit_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bit width of one buffer entry.
REQ-002 SHALL have parameter DEPTH, default 16 (power of 2, >=2): entries per credit-type buffer.
REQ-003 SHALL have parameter NUM_TYPES, default 6: credit types (0=PH, 1=PD, 2=NPH, 3=NPD, 4=CplH, 5=CplD).
REQ-004 SHALL have parameter CL_WIDTH, default 12: credit limit counter width.
REQ-005 SHALL have parameter UPDATE_THRESH, default 4: freed credits that force an update request.
REQ-006 SHALL have parameter UPDATE_TIMER, default 64: cycles between periodic update checks.
REQ-007 SHALL have parameter INFINITE_MASK, default 0 (NUM_TYPES bits): bit i set means type i advertises infinite credits.
REQ-008 SHALL have port clk  input  1  single clock for all types; one clock, reset is asynchronous and active-low.
REQ-009 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-010 SHALL have port wr_en  input  NUM_TYPES  per-type write strobe.
REQ-011 SHALL have port rd_en  input  NUM_TYPES  per-type read strobe.
REQ-012 SHALL have port data_in  input  NUM_TYPES*DATA_WIDTH  type i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port data_out  output  NUM_TYPES*DATA_WIDTH  registered read data, same slicing.
REQ-014 SHALL have port full  output  NUM_TYPES  per-type full flag.
REQ-015 SHALL have port empty  output  NUM_TYPES  per-type empty flag.
REQ-016 SHALL have port credit_limit  output  NUM_TYPES*CL_WIDTH  per-type advertised limit.
REQ-017 SHALL have port update_req  output  NUM_TYPES  per-type UpdateFC request.
REQ-018 SHALL have port update_ack  input  NUM_TYPES  per-type request acknowledge.
REQ-019 SHALL have port overflow_err  output  NUM_TYPES  sticky per-type overflow error.

Function
REQ-020 SHALL implement each type as an independent FIFO with wrapping pointers and an occupancy count 0..DEPTH.
REQ-021 SHALL drive combinational flags: full[i] when count==DEPTH, empty[i] when count==0.
REQ-022 SHALL accept a write when wr_en[i] and (!full[i] or rd_en[i] accepted the same cycle).
REQ-023 SHALL ignore a write to a full buffer with no accepted read, leave contents unchanged, and set overflow_err[i] next cycle; it stays set until reset.
REQ-024 SHALL accept a read when rd_en[i] and !empty[i], updating data_out slice i on the next edge (1-cycle latency).
REQ-025 SHALL hold data_out slice i when a read is not accepted; a read when empty has no effect and flags no error.
REQ-026 SHALL, when write and read are both accepted, leave count unchanged; on an empty buffer only the write is accepted.
REQ-027 SHALL increment credit_limit[i] by 1 per accepted read, modulo 2^CL_WIDTH (wrap from all-ones to 0).
REQ-028 SHALL, for INFINITE_MASK[i]=1, hold credit_limit[i] at 0 and update_req[i] at 0; the FIFO still operates normally.
REQ-029 SHALL keep a per-type pending count of freed credits since the last acknowledged update, saturating at DEPTH.
REQ-030 SHALL run one free-running timer 0..UPDATE_TIMER-1 that pulses expire for one cycle at UPDATE_TIMER-1, then wraps to 0.
REQ-031 SHALL set update_req[i] next cycle when pending[i] reaches UPDATE_THRESH or when expire and pending[i]>0.
REQ-032 SHALL hold update_req[i] high until update_ack[i]; on ack with req high, clear req and set pending to 1 if a read is accepted that cycle, else 0.
REQ-033 SHALL ignore update_ack[i] while update_req[i] is low.

Reset
REQ-034 SHALL on rst_n low immediately clear pointers, counts, pending, timer, data_out, update_req and overflow_err, drive empty=all-ones and full=0, and set credit_limit[i] to DEPTH mod 2^CL_WIDTH (0 if infinite).
REQ-035 SHALL discard any in-flight write, read or request when reset asserts mid-operation; behaviour resumes on the first clk edge after rst_n deasserts.

Verification
REQ-036 SHALL test: reset, then 16 writes to type 0 -> full[0]=1, credit_limit[0]=16; 17th write -> overflow_err[0]=1, contents intact.
REQ-037 SHALL test: write A5,3C to type 1, then read twice -> data_out[15:8]=A5 then 3C one cycle after each read; credit_limit[1]=18; empty[1]=1.
REQ-038 SHALL test: 4 reads on type 2 -> update_req[2]=1 next cycle; ack during a simultaneous read -> req=0, pending=1.
REQ-039 SHALL test: 1 read on type 3, no more traffic -> update_req[3] rises the cycle after timer expire.
REQ-040 SHALL test: full buffer with simultaneous wr_en and rd_en -> both accepted, full stays 1, no error; INFINITE_MASK=6'b100000 -> credit_limit[5]=0 and update_req[5]=0 throughout.
REQ-041 SHALL test: credit_limit preset at 4095 by 4079 reads after reset; one more read -> credit_limit wraps to 0; rst_n pulse mid-burst -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rx_fc_credit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rx_fc_credit_buffer
// Purpose  : Receive-side flow-control credit buffer. One independent FIFO
//            per credit type (PH, PD, NPH, NPD, CplH, CplD). Each FIFO tracks
//            an advertised credit limit and requests an UpdateFC when enough
//            credits have been freed or when the periodic timer expires.
// Ports    : clk, rst_n        - single clock, async active-low reset
//            wr_en/rd_en       - per-type write/read strobes
//            data_in/data_out  - per-type data, slice i at [i*DATA_WIDTH +: DATA_WIDTH]
//            full/empty        - per-type occupancy flags (combinational)
//            credit_limit      - per-type advertised limit, slice i at [i*CL_WIDTH +: CL_WIDTH]
//            update_req/ack    - per-type UpdateFC handshake
//            overflow_err      - sticky per-type write-to-full error
// Revision : 1.0 - initial release
// ============================================================================
module rx_fc_credit_buffer #(
    parameter int                   DATA_WIDTH    = 8,
    parameter int                   DEPTH         = 16,
    parameter int                   NUM_TYPES     = 6,
    parameter int                   CL_WIDTH      = 12,
    parameter int                   UPDATE_THRESH = 4,
    parameter int                   UPDATE_TIMER  = 64,
    parameter logic [NUM_TYPES-1:0] INFINITE_MASK = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_TYPES-1:0]            wr_en,
    input  logic [NUM_TYPES-1:0]            rd_en,
    input  logic [NUM_TYPES*DATA_WIDTH-1:0] data_in,
    output logic [NUM_TYPES*DATA_WIDTH-1:0] data_out,
    output logic [NUM_TYPES-1:0]            full,
    output logic [NUM_TYPES-1:0]            empty,
    output logic [NUM_TYPES*CL_WIDTH-1:0]   credit_limit,
    output logic [NUM_TYPES-1:0]            update_req,
    input  logic [NUM_TYPES-1:0]            update_ack,
    output logic [NUM_TYPES-1:0]            overflow_err
);

    localparam int                 c_AW     = $clog2(DEPTH);
    localparam int                 c_CW     = c_AW + 1;
    localparam int                 c_TW     = (UPDATE_TIMER > 1) ? $clog2(UPDATE_TIMER) : 1;
    localparam logic [c_CW-1:0]     c_DEPTH  = c_CW'(DEPTH);
    localparam logic [c_TW-1:0]     c_TMAX   = c_TW'(UPDATE_TIMER - 1);
    localparam logic [CL_WIDTH-1:0] c_CL_RST = CL_WIDTH'(DEPTH);

    // Shared periodic timer; w_expire is high for the single cycle at the top count.
    logic [c_TW-1:0] r_timer;
    logic            w_expire;

    assign w_expire = (r_timer == c_TMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_expire) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_TW'(1);
        end
    end

    for (genvar g = 0; g < NUM_TYPES; g++) begin : g_type
        localparam bit c_INF = INFINITE_MASK[g];

        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [c_AW-1:0]       r_wr_ptr;
        logic [c_AW-1:0]       r_rd_ptr;
        logic [c_CW-1:0]       r_count;
        logic [c_CW-1:0]       r_pending;
        logic [DATA_WIDTH-1:0] r_dout;
        logic [CL_WIDTH-1:0]   r_cl;
        logic                  r_req;
        logic                  r_ovf;

        logic w_full;
        logic w_empty;
        logic w_rd_acc;
        logic w_wr_acc;
        logic w_ack;
        logic w_trig;

        assign w_full   = (r_count == c_DEPTH);
        assign w_empty  = (r_count == '0);
        assign w_rd_acc = rd_en[g] & ~w_empty;
        // A read in the same cycle frees a slot, so a full buffer can still take a write.
        assign w_wr_acc = wr_en[g] & (~w_full | w_rd_acc);
        // Acks are meaningful only while a request is outstanding.
        assign w_ack    = update_ack[g] & r_req;
        assign w_trig   = (int'(r_pending) >= UPDATE_THRESH) ||
                          (w_expire && (r_pending != '0));

        // Storage carries no reset: pointers and count define validity.
        always_ff @(posedge clk) begin
            if (w_wr_acc) begin
                r_mem[r_wr_ptr] <= data_in[g*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_pending <= '0;
                r_dout    <= '0;
                r_cl      <= c_INF ? '0 : c_CL_RST;
                r_req     <= 1'b0;
                r_ovf     <= 1'b0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + c_AW'(1);
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= r_rd_ptr + c_AW'(1);
                    r_dout   <= r_mem[r_rd_ptr];
                end
                unique case ({w_wr_acc, w_rd_acc})
                    2'b10:   r_count <= r_count + c_CW'(1);
                    2'b01:   r_count <= r_count - c_CW'(1);
                    default: r_count <= r_count;
                endcase

                if (wr_en[g] && !w_wr_acc) begin
                    r_ovf <= 1'b1;
                end

                if (!c_INF && w_rd_acc) begin
                    r_cl <= r_cl + CL_WIDTH'(1);
                end

                // A read coinciding with the ack is the first credit of the next update.
                if (w_ack) begin
                    r_req     <= 1'b0;
                    r_pending <= c_CW'(w_rd_acc);
                end else begin
                    if (!c_INF && !r_req && w_trig) begin
                        r_req <= 1'b1;
                    end
                    if (w_rd_acc && (r_pending != c_DEPTH)) begin
                        r_pending <= r_pending + c_CW'(1);
                    end
                end
            end
        end

        assign full[g]                                 = w_full;
        assign empty[g]                                = w_empty;
        assign data_out[g*DATA_WIDTH +: DATA_WIDTH]    = r_dout;
        assign credit_limit[g*CL_WIDTH +: CL_WIDTH]    = r_cl;
        assign update_req[g]                           = r_req;
        assign overflow_err[g]                         = r_ovf;
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_fc_credit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_fc_credit_buffer
// Purpose  : Self-checking bench for rx_fc_credit_buffer. A queue-based model
//            of every credit type is compared with the DUT on each falling
//            edge; directed sequences add hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_fc_credit_buffer;

    localparam int         NT   = 6;
    localparam int         DW   = 8;
    localparam int         D    = 16;
    localparam int         CLW  = 12;
    localparam int         TH   = 4;
    localparam int         TMR  = 64;
    localparam logic [5:0] MASK = 6'b100000;
    localparam logic [71:0] CL_RESET = 72'h000_010_010_010_010_010;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic [5:0]  wr_en      = '0;
    logic [5:0]  rd_en      = '0;
    logic [5:0]  update_ack = '0;
    logic [47:0] data_in    = '0;
    wire  [47:0] data_out;
    wire  [5:0]  full;
    wire  [5:0]  empty;
    wire  [71:0] credit_limit;
    wire  [5:0]  update_req;
    wire  [5:0]  overflow_err;

    rx_fc_credit_buffer #(
        .DATA_WIDTH    (DW),
        .DEPTH         (D),
        .NUM_TYPES     (NT),
        .CL_WIDTH      (CLW),
        .UPDATE_THRESH (TH),
        .UPDATE_TIMER  (TMR),
        .INFINITE_MASK (MASK)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .credit_limit (credit_limit),
        .update_req   (update_req),
        .update_ack   (update_ack),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mq [NT][$];
    int         mcl   [NT];
    int         mpend [NT];
    bit         mreq  [NT];
    bit         movf  [NT];
    logic [7:0] mdout [NT];
    int         mtimer;
    bit         m_expire;
    bit         m_rok;
    bit         m_wok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) begin
                mq[i].delete();
                mcl[i]   = MASK[i] ? 0 : (D % (1 << CLW));
                mpend[i] = 0;
                mreq[i]  = 0;
                movf[i]  = 0;
                mdout[i] = '0;
            end
            mtimer = 0;
        end else begin
            m_expire = (mtimer == TMR - 1);
            for (int i = 0; i < NT; i++) begin
                m_rok = rd_en[i] && (mq[i].size() > 0);
                m_wok = wr_en[i] && ((mq[i].size() < D) || m_rok);
                if (m_rok) begin
                    mdout[i] = mq[i].pop_front();
                    if (!MASK[i]) mcl[i] = (mcl[i] + 1) % (1 << CLW);
                end
                if (m_wok) mq[i].push_back(data_in[i*8 +: 8]);
                else if (wr_en[i]) movf[i] = 1;
                if (mreq[i] && update_ack[i]) begin
                    mreq[i]  = 0;
                    mpend[i] = m_rok ? 1 : 0;
                end else begin
                    if (!MASK[i] && !mreq[i] && (mpend[i] >= TH || (m_expire && mpend[i] > 0)))
                        mreq[i] = 1;
                    if (m_rok && mpend[i] < D) mpend[i]++;
                end
            end
            mtimer = (mtimer + 1) % TMR;
        end
    end

    // ---------------- per-cycle comparison ----------------
    logic [47:0] e_dout;
    logic [71:0] e_cl;
    logic [5:0]  e_full, e_empty, e_req, e_ovf;

    always @(negedge clk) begin
        for (int i = 0; i < NT; i++) begin
            e_dout[i*8 +: 8]   = mdout[i];
            e_cl[i*12 +: 12]   = 12'(mcl[i]);
            e_full[i]          = (mq[i].size() == D);
            e_empty[i]         = (mq[i].size() == 0);
            e_req[i]           = mreq[i];
            e_ovf[i]           = movf[i];
        end
        chk("cmp_data_out",     128'(data_out),     128'(e_dout));
        chk("cmp_credit_limit", 128'(credit_limit), 128'(e_cl));
        chk("cmp_full",         128'(full),         128'(e_full));
        chk("cmp_empty",        128'(empty),        128'(e_empty));
        chk("cmp_update_req",   128'(update_req),   128'(e_req));
        chk("cmp_overflow_err", 128'(overflow_err), 128'(e_ovf));
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [47:0] dsl(input int t, input logic [7:0] v);
        logic [47:0] x;
        x = 48'(v);
        return x << (t * 8);
    endfunction

    task automatic step(input logic [5:0] w, input logic [5:0] r, input logic [5:0] a,
                        input logic [47:0] d);
        wr_en = w; rd_en = r; update_ack = a; data_in = d;
        @(posedge clk);
        #1;
        wr_en = '0; rd_en = '0; update_ack = '0; data_in = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_empty"},   128'(empty),        128'(6'h3f));
        chk({tag, "_full"},    128'(full),         128'(6'h00));
        chk({tag, "_dout"},    128'(data_out),     128'(48'h0));
        chk({tag, "_req"},     128'(update_req),   128'(6'h00));
        chk({tag, "_ovf"},     128'(overflow_err), 128'(6'h00));
        chk({tag, "_cl"},      128'(credit_limit), 128'(CL_RESET));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Type 0: fill, overflow, drain with contents intact
        for (int k = 0; k < 16; k++) step(6'h01, 6'h00, 6'h00, dsl(0, 8'(8'h10 + k)));
        chk("t0_full", 128'(full[0]), 128'(1'b1));
        chk("t0_cl16", 128'(credit_limit[11:0]), 128'(12'd16));
        step(6'h01, 6'h00, 6'h00, dsl(0, 8'hFF));
        chk("t0_ovf", 128'(overflow_err[0]), 128'(1'b1));
        chk("t0_full_after_ovf", 128'(full[0]), 128'(1'b1));
        for (int k = 0; k < 16; k++) begin
            step(6'h00, 6'h01, 6'h00, '0);
            chk("t0_drain_data", 128'(data_out[7:0]), 128'(8'(8'h10 + k)));
        end
        chk("t0_empty", 128'(empty[0]), 128'(1'b1));
        chk("t0_cl32", 128'(credit_limit[11:0]), 128'(12'd32));

        // Type 1: two writes, two reads
        step(6'h02, 6'h00, 6'h00, dsl(1, 8'hA5));
        step(6'h02, 6'h00, 6'h00, dsl(1, 8'h3C));
        step(6'h00, 6'h02, 6'h00, '0);
        chk("t1_rd_a5", 128'(data_out[15:8]), 128'(8'hA5));
        step(6'h00, 6'h02, 6'h00, '0);
        chk("t1_rd_3c", 128'(data_out[15:8]), 128'(8'h3C));
        chk("t1_cl18", 128'(credit_limit[23:12]), 128'(12'd18));
        chk("t1_empty", 128'(empty[1]), 128'(1'b1));

        // Type 2: threshold request, ack with simultaneous read
        n = 0;
        while (mtimer != 2 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t2_timer_align", 128'(n < 200), 128'(1'b1));
        for (int k = 0; k < 8; k++) step(6'h04, 6'h00, 6'h00, dsl(2, 8'(8'h20 + k)));
        for (int k = 0; k < 4; k++) step(6'h00, 6'h04, 6'h00, '0);
        chk("t2_req_not_yet", 128'(update_req[2]), 128'(1'b0));
        step(6'h00, 6'h00, 6'h00, '0);
        chk("t2_req_set", 128'(update_req[2]), 128'(1'b1));
        step(6'h00, 6'h00, 6'h00, '0);
        chk("t2_req_held", 128'(update_req[2]), 128'(1'b1));
        step(6'h00, 6'h04, 6'h04, '0);
        chk("t2_req_cleared", 128'(update_req[2]), 128'(1'b0));
        step(6'h00, 6'h04, 6'h00, '0);
        step(6'h00, 6'h04, 6'h00, '0);
        step(6'h00, 6'h04, 6'h00, '0);
        chk("t2_pend_from_one", 128'(update_req[2]), 128'(1'b0));
        step(6'h00, 6'h00, 6'h00, '0);
        chk("t2_req_again", 128'(update_req[2]), 128'(1'b1));
        step(6'h00, 6'h00, 6'h04, '0);
        chk("t2_req_acked", 128'(update_req[2]), 128'(1'b0));

        // Type 3: single read, timer-driven request
        step(6'h08, 6'h00, 6'h00, dsl(3, 8'h77));
        step(6'h00, 6'h08, 6'h00, '0);
        chk("t3_data", 128'(data_out[31:24]), 128'(8'h77));
        chk("t3_no_req_yet", 128'(update_req[3]), 128'(1'b0));
        n = 0;
        while (!update_req[3] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_req_rise", 128'(update_req[3]), 128'(1'b1));
        chk("t3_req_after_expire", 128'(mtimer), 128'(0));

        // Type 5 (infinite): full with simultaneous write and read
        for (int k = 0; k < 16; k++) step(6'h20, 6'h00, 6'h00, dsl(5, 8'(8'h50 + k)));
        chk("t5_full", 128'(full[5]), 128'(1'b1));
        step(6'h20, 6'h20, 6'h00, dsl(5, 8'hEE));
        chk("t5_full_kept", 128'(full[5]), 128'(1'b1));
        chk("t5_no_ovf", 128'(overflow_err[5]), 128'(1'b0));
        chk("t5_data", 128'(data_out[47:40]), 128'(8'h50));
        chk("t5_cl0", 128'(credit_limit[71:60]), 128'(12'd0));
        repeat (70) step(6'h00, 6'h00, 6'h00, '0);
        chk("t5_no_req", 128'(update_req[5]), 128'(1'b0));

        // Type 4: credit limit wrap
        step(6'h10, 6'h00, 6'h00, dsl(4, 8'h00));
        for (int k = 0; k < 4079; k++) step(6'h10, 6'h10, 6'h00, dsl(4, 8'(k + 1)));
        chk("t4_cl4095", 128'(credit_limit[59:48]), 128'(12'hFFF));
        step(6'h10, 6'h10, 6'h00, dsl(4, 8'(4080)));
        chk("t4_cl_wrap", 128'(credit_limit[59:48]), 128'(12'h000));
        chk("t4_data", 128'(data_out[39:32]), 128'(8'hEF));

        // Asynchronous reset mid-burst
        wr_en = 6'h10; rd_en = 6'h10; data_in = dsl(4, 8'hAB);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        chk_reset_outputs("rst_held");
        wr_en = '0; rd_en = '0; data_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(6'h10, 6'h00, 6'h00, dsl(4, 8'h5A));
        chk("resume_not_empty", 128'(empty[4]), 128'(1'b0));
        step(6'h00, 6'h10, 6'h00, '0);
        chk("resume_data", 128'(data_out[39:32]), 128'(8'h5A));
        chk("resume_cl17", 128'(credit_limit[59:48]), 128'(12'd17));

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
